multicycle_ctrl: RTL and testbench

- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Drives every datapath mux select (PC source, ALU operand sources, register destination, writeback source, memory address source) and every write strobe.
- Handshakes with the unified instruction/data memory and raises a sticky trap on an illegal opcode or a memory timeout.

---
 rtl/mips_ctrl_pkg.sv | 137 +++++++++++++
 rtl/mem_timeout_cnt.sv | 36 +++
 rtl/multicycle_ctrl.sv | 143 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// Optional bne support is selected by MULTICYCLE_CTRL_BNE_EN in multicycle_ctrl.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_RTYPE  = 4'd7,
        ST_RTWB   = 4'd8,
        ST_BRANCH = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_JUMP   = 4'd12,
        ST_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUB_REGB   = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    // Moore outputs per state; the *_rdy / *_br strobes are later qualified
    // by mem_ready / zero so the registered part stays a pure state decode.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write_rdy;
        logic       pc_write_rdy;
        logic       pc_write_br;
        logic       pc_write_uncond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       trap;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_req      = 1'b1;
                c.iord         = 1'b0;
                c.alu_src_a    = 1'b0;
                c.alu_src_b    = ALUB_FOUR;
                c.alu_op       = ALUOP_ADD;
                c.pc_src       = PC_SRC_ALU;
                c.ir_write_rdy = 1'b1;
                c.pc_write_rdy = 1'b1;
            end
            ST_DECODE: begin
                c.alu_src_a = 1'b0;
                c.alu_src_b = ALUB_IMM_SH;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            ST_MEMWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b0;
                c.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_RTYPE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUB_REGB;
                c.alu_op    = ALUOP_FUNCT;
            end
            ST_RTWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.mem_to_reg = 1'b0;
            end
            ST_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = ALUB_REGB;
                c.alu_op      = ALUOP_SUB;
                c.pc_src      = PC_SRC_ALUOUT;
                c.pc_write_br = 1'b1;
            end
            ST_ADDIWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b0;
                c.mem_to_reg = 1'b0;
            end
            ST_JUMP: begin
                c.pc_src          = PC_SRC_JUMP;
                c.pc_write_uncond = 1'b1;
            end
            ST_TRAP: begin
                c.trap = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating wait counter for memory handshakes; expired flags the configured
// wait limit. A limit of 0 never expires.
module mem_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               ENABLED = (TIMEOUT_CYCLES != 32'sd0);

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle count: clear wins over increment, and it holds at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = ENABLED && (cnt_r == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath with memory timeout trap.
// Define MULTICYCLE_CTRL_BNE_EN to accept bne (opcode 0x05) as a branch.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       trap
);

    state_t state_r;
    state_t next_s;
    ctrl_t  ctrl_r;
    logic   expired_s;
    logic   cnt_clr_s;
    logic   cnt_en_s;
    logic   branch_taken_s;

    // Next-state decode; unreachable encodings fall into TRAP.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_RESET: next_s = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)      next_s = ST_DECODE;
                else if (expired_s) next_s = ST_TRAP;
                else                next_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_s = ST_MEMADR;
                    OP_RTYPE:     next_s = ST_RTYPE;
                    OP_BEQ:       next_s = ST_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:       next_s = ST_BRANCH;
`endif
                    OP_ADDI:      next_s = ST_ADDIEX;
                    OP_J:         next_s = ST_JUMP;
                    default:      next_s = ST_TRAP;
                endcase
            end
            ST_MEMADR: begin
                if (opcode == OP_LW) next_s = ST_MEMRD;
                else                 next_s = ST_MEMWR;
            end
            ST_MEMRD: begin
                if (mem_ready)      next_s = ST_MEMWB;
                else if (expired_s) next_s = ST_TRAP;
                else                next_s = ST_MEMRD;
            end
            ST_MEMWR: begin
                if (mem_ready)      next_s = ST_FETCH;
                else if (expired_s) next_s = ST_TRAP;
                else                next_s = ST_MEMWR;
            end
            ST_MEMWB, ST_RTWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: next_s = ST_FETCH;
            ST_RTYPE:  next_s = ST_RTWB;
            ST_ADDIEX: next_s = ST_ADDIWB;
            ST_TRAP:   next_s = ST_TRAP;
            default:   next_s = ST_TRAP;
        endcase
    end

    // Any state change restarts the wait count, so each access starts from 0.
    assign cnt_clr_s = (next_s != state_r);
    assign cnt_en_s  = ctrl_r.mem_req & ~mem_ready;

    mem_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .expired (expired_s)
    );

    // State register with outputs pre-decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RESET;
            ctrl_r  <= '0;
        end else begin
            state_r <= next_s;
            ctrl_r  <= ctrl_decode(next_s);
        end
    end

`ifdef MULTICYCLE_CTRL_BNE_EN
    logic is_bne_r;

    // Branch sense captured while the instruction register is known stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_bne_r <= 1'b0;
        end else if (state_r == ST_DECODE) begin
            is_bne_r <= (opcode == OP_BNE);
        end else begin
            is_bne_r <= is_bne_r;
        end
    end

    assign branch_taken_s = is_bne_r ? ~zero : zero;
`else
    assign branch_taken_s = zero;
`endif

    assign mem_req    = ctrl_r.mem_req;
    assign mem_write  = ctrl_r.mem_write;
    assign iord       = ctrl_r.iord;
    assign ir_write   = ctrl_r.ir_write_rdy & mem_ready;
    assign pc_write   = (ctrl_r.pc_write_rdy & mem_ready)
                      | (ctrl_r.pc_write_br & branch_taken_s)
                      | ctrl_r.pc_write_uncond;
    assign pc_src     = ctrl_r.pc_src;
    assign alu_src_a  = ctrl_r.alu_src_a;
    assign alu_src_b  = ctrl_r.alu_src_b;
    assign alu_op     = ctrl_r.alu_op;
    assign reg_dst    = ctrl_r.reg_dst;
    assign mem_to_reg = ctrl_r.mem_to_reg;
    assign reg_write  = ctrl_r.reg_write;
    assign trap       = ctrl_r.trap;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: instruction-level schedule model plus directed pins.
module tb_multicycle_ctrl;

    // A limit of 4 lets a 4-cycle-late store complete (ready wins at the limit).
    localparam int TMO = 4;

`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    localparam int P_RESET = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                   P_MEMWB = 5, P_MEMWR = 6, P_RTYPE = 7, P_RTWB = 8, P_BRANCH = 9,
                   P_ADDIEX = 10, P_ADDIWB = 11, P_JUMP = 12, P_TRAP = 13;

    localparam int L_NONE = 0, L_ZERO = 1, L_FETCH = 2, L_LW = 3, L_SW = 4, L_TMO = 5,
                   L_TRAP = 6, L_BEQ1 = 7, L_BEQ0 = 8, L_J = 9, L_BNE = 10,
                   L_MRD_RST = 11, L_NOTRAP = 12;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [5:0] opcode;
    logic       mem_req, mem_write, iord, ir_write, pc_write, alu_src_a;
    logic       reg_dst, mem_to_reg, reg_write, trap;
    logic [1:0] pc_src, alu_src_b, alu_op;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .trap(trap)
    );

    typedef struct packed {
        logic mem_req; logic mem_write; logic iord; logic ir_write; logic pc_write;
        logic [1:0] pc_src; logic alu_src_a; logic [1:0] alu_src_b; logic [1:0] alu_op;
        logic reg_dst; logic mem_to_reg; logic reg_write; logic trap;
    } ov_t;

    ov_t act_v, exp_v;
    bit  exp_valid = 1'b0;
    bit  win = 1'b0;
    int  lit_sel = L_NONE;
    int  cur_ph = P_RESET;
    int  checks = 0, errors = 0;
    int  cyc = 0, last_irw = 0, last_rw = 0, mw_win = 0, rw_win = 0, mreq_win = 0;

    assign act_v = {mem_req, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
                    alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, trap};

    // Expected outputs straight from the per-state output table.
    function automatic ov_t model(int ph, logic rdy, logic z, logic bne);
        ov_t o;
        o = '0;
        case (ph)
            P_FETCH:  begin o.mem_req = 1'b1; o.alu_src_b = 2'd1; o.ir_write = rdy; o.pc_write = rdy; end
            P_DECODE: o.alu_src_b = 2'd3;
            P_MEMADR, P_ADDIEX: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
            P_MEMRD:  begin o.mem_req = 1'b1; o.iord = 1'b1; end
            P_MEMWB:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            P_MEMWR:  begin o.mem_req = 1'b1; o.mem_write = 1'b1; o.iord = 1'b1; end
            P_RTYPE:  begin o.alu_src_a = 1'b1; o.alu_op = 2'd2; end
            P_RTWB:   begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            P_BRANCH: begin o.alu_src_a = 1'b1; o.alu_op = 2'd1; o.pc_src = 2'd1;
                            o.pc_write = bne ? ~z : z; end
            P_ADDIWB: o.reg_write = 1'b1;
            P_JUMP:   begin o.pc_src = 2'd2; o.pc_write = 1'b1; end
            P_TRAP:   o.trap = 1'b1;
            default:  o = '0;
        endcase
        return o;
    endfunction

    task automatic lit(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, a, e);
        end
    endtask

    // Single compare process: model check every cycle plus scheduled literal pins.
    always @(negedge clk) begin
        cyc++;
        if (ir_write === 1'b1) last_irw = cyc;
        if (reg_write === 1'b1) last_rw = cyc;
        if (win) begin
            if (mem_write === 1'b1) mw_win++;
            if (reg_write === 1'b1) rw_win++;
            if (mem_req === 1'b1) mreq_win++;
        end else begin
            mw_win = 0; rw_win = 0; mreq_win = 0;
        end
        if (exp_valid) begin
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs cyc=%0d phase=%0d act=%b exp=%b", cyc, cur_ph, act_v, exp_v);
            end
        end
        case (lit_sel)
            L_ZERO:    lit("reset_zero", {16'd0, act_v}, 32'd0);
            L_FETCH:   lit("fetch_req_iord", {30'd0, mem_req, iord}, 32'd2);
            L_LW:      lit("lw_wb_span", 32'(last_rw - last_irw), 32'd4);
            L_SW:      lit("sw_mw_rw", {mw_win[15:0], rw_win[15:0]}, {16'd5, 16'd0});
            L_TMO:     lit("timeout_fetch_cycles", 32'(mreq_win), 32'(TMO + 1));
            L_TRAP:    lit("trap_held", {31'd0, trap}, 32'd1);
            L_BEQ1:    lit("beq_taken", {29'd0, pc_write, pc_src}, 32'd5);
            L_BEQ0:    lit("beq_not_taken", {31'd0, pc_write}, 32'd0);
            L_J:       lit("jump", {29'd0, pc_write, pc_src}, 32'd6);
            L_BNE:     lit("bne_taken", {31'd0, pc_write}, 32'd1);
            L_MRD_RST: lit("memrd_reset_req", {31'd0, mem_req}, 32'd0);
            L_NOTRAP:  lit("ready_at_limit", {30'd0, trap, mem_req}, 32'd0);
            default:   ;
        endcase
    end

    task automatic emit(input int ph, input logic rdy, input logic z, input logic bne, input int l);
        mem_ready = rdy;
        zero      = z;
        cur_ph    = ph;
        exp_v     = model(ph, rdy, z, bne);
        exp_valid = 1'b1;
        lit_sel   = l;
        @(posedge clk);
        #1;
        lit_sel   = L_NONE;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic do_reset(input int prev, input int lb);
        rst_n = 1'b0;
        if (prev >= 0) begin
            emit(prev, 1'b0, rb(), 1'b0, L_NONE);
        end else begin
            exp_valid = 1'b0; mem_ready = 1'b0; zero = 1'b0;
            @(posedge clk); #1;
        end
        emit(P_RESET, rb(), rb(), 1'b0, lb);
        emit(P_RESET, rb(), rb(), 1'b0, L_NONE);
        rst_n = 1'b1;
        emit(P_RESET, rb(), rb(), 1'b0, L_ZERO);
    endtask

    task automatic trap_recover();
        repeat ($urandom_range(4, 1)) emit(P_TRAP, rb(), rb(), 1'b0, L_TRAP);
        do_reset(P_TRAP, L_NONE);
    endtask

    // Memory wait: completes on cycle lat, or traps after TMO+1 unanswered cycles.
    task automatic mem_phase(input int ph, input int lat, input int lph, input int lc, output bit trapped);
        trapped = 1'b0;
        for (int i = 0; ; i++) begin
            logic rdy;
            rdy = (i == lat);
            emit(ph, rdy, rb(), 1'b0, (ph == lph && rdy) ? lc : L_NONE);
            if (rdy) break;
            if (i == TMO) begin trapped = 1'b1; break; end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int lf, input int lm, input logic zb,
                             input int lph, input int lc);
        bit t;
        opcode = op;
        mem_phase(P_FETCH, lf, lph, lc, t);
        if (t) begin trap_recover(); return; end
        emit(P_DECODE, rb(), rb(), 1'b0, (lph == P_DECODE) ? lc : L_NONE);
        if (op == 6'h23 || op == 6'h2B) begin
            emit(P_MEMADR, rb(), rb(), 1'b0, L_NONE);
            if (op == 6'h23) begin
                mem_phase(P_MEMRD, lm, lph, lc, t);
                if (t) begin trap_recover(); return; end
                emit(P_MEMWB, rb(), rb(), 1'b0, (lph == P_MEMWB) ? lc : L_NONE);
            end else begin
                mem_phase(P_MEMWR, lm, lph, lc, t);
                if (t) begin trap_recover(); return; end
            end
        end else if (op == 6'h00) begin
            emit(P_RTYPE, rb(), rb(), 1'b0, L_NONE);
            emit(P_RTWB, rb(), rb(), 1'b0, L_NONE);
        end else if (op == 6'h04 || (op == 6'h05 && BNE_EN)) begin
            emit(P_BRANCH, rb(), zb, (op == 6'h05), (lph == P_BRANCH) ? lc : L_NONE);
        end else if (op == 6'h08) begin
            emit(P_ADDIEX, rb(), rb(), 1'b0, L_NONE);
            emit(P_ADDIWB, rb(), rb(), 1'b0, L_NONE);
        end else if (op == 6'h02) begin
            emit(P_JUMP, rb(), rb(), 1'b0, (lph == P_JUMP) ? lc : L_NONE);
        end else begin
            trap_recover();
        end
    endtask

    logic [5:0] ops [7];

    initial begin
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05};
        rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;

        do_reset(-1, L_NONE);
        run_instr(6'h08, 0, 0, 1'b0, P_FETCH, L_FETCH);
        run_instr(6'h23, 0, 0, 1'b0, P_MEMWB, L_LW);
        win = 1'b1;
        run_instr(6'h2B, 0, 4, 1'b0, P_MEMWR, L_SW);
        win = 1'b0;
        run_instr(6'h04, 0, 0, 1'b1, P_BRANCH, L_BEQ1);
        run_instr(6'h04, 0, 0, 1'b0, P_BRANCH, L_BEQ0);
        run_instr(6'h02, 0, 0, 1'b0, P_JUMP, L_J);

        // Fetch never answered: trap after TMO+1 request cycles, held until reset.
        opcode = 6'h00;
        win = 1'b1;
        for (int i = 0; i <= TMO; i++) emit(P_FETCH, 1'b0, rb(), 1'b0, (i == TMO) ? L_TMO : L_NONE);
        win = 1'b0;
        repeat (5) emit(P_TRAP, rb(), rb(), 1'b0, L_TRAP);
        do_reset(P_TRAP, L_NONE);
        run_instr(6'h00, TMO, 0, 1'b0, P_DECODE, L_NOTRAP);

        run_instr(6'h3F, 0, 0, 1'b0, P_NONE_PH(), L_NONE);
        run_instr(6'h05, 0, 0, 1'b0, P_BRANCH, L_BNE);

        // Reset asserted in the middle of a load access.
        opcode = 6'h23;
        emit(P_FETCH, 1'b1, rb(), 1'b0, L_NONE);
        emit(P_DECODE, rb(), rb(), 1'b0, L_NONE);
        emit(P_MEMADR, rb(), rb(), 1'b0, L_NONE);
        emit(P_MEMRD, 1'b0, rb(), 1'b0, L_NONE);
        do_reset(P_MEMRD, L_MRD_RST);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            int lf, lm;
            op = ($urandom_range(99, 0) < 85) ? ops[$urandom_range(6, 0)] : 6'($urandom);
            lf = ($urandom_range(19, 0) == 0) ? $urandom_range(TMO + 3, TMO + 1) : $urandom_range(TMO, 0);
            lm = ($urandom_range(19, 0) == 0) ? $urandom_range(TMO + 3, TMO + 1) : $urandom_range(TMO, 0);
            run_instr(op, lf, lm, rb(), -1, L_NONE);
        end

        exp_valid = 1'b0;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic int P_NONE_PH();
        return -1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
